// File: rtl/alu_signmag_seq.sv
// alu_signmag_seq: multi-cycle sign-magnitude ADD/SUB/MUL/DIV/MOD, valid/ready.
// Define ALU_FLAGS_EN to register {ovf, dz, neg, zero}; otherwise flags read 0.
module alu_signmag_seq #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] res_c,
  output logic [N-1:0]   res_sm,
  output logic [3:0]     flags
);
  localparam int M  = N - 1;
  localparam int W  = 2 * N;
  localparam int CW = $clog2(M) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_res_c;
  logic [N-1:0]   r_res_sm;
  logic [2:0]     r_op;
  logic           r_sa;
  logic           r_sb;
  logic [M-1:0]   r_ma;
  logic [M-1:0]   r_mb;
  logic [2*M-1:0] r_acc;
  logic [2*M-1:0] r_mcand;
  logic [M-1:0]   r_mplier;
  logic [M-1:0]   r_rem;
  logic [M-1:0]   r_quo;
  logic [CW-1:0]  r_cnt;

  logic [2*M-1:0] w_acc_nx;
  logic [M:0]     w_sh;
  logic           w_ge;
  logic [M-1:0]   w_diff;
  logic [M-1:0]   w_rem_nx;
  logic [M-1:0]   w_quo_nx;
  logic           w_dz;
  logic           w_divop;
  logic           w_iter;
  logic           w_last;
  logic [W-1:0]   w_va;
  logic [W-1:0]   w_vb;
  logic [W-1:0]   w_res;
  logic           w_neg;
  logic [M-1:0]   w_lo;
  logic [M-1:0]   w_smag;
  logic [N-1:0]   w_sm;

  function automatic logic [W-1:0] f_sgn(
    input logic         s,
    input logic [W-1:0] m
  );
    return s ? (W'(0) - m) : m;
  endfunction

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res_c     = r_res_c;
  assign res_sm    = r_res_sm;

  // One shift-add step and one restoring-division step per EXEC cycle
  assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_sh     = {r_rem, r_quo[M-1]};
  assign w_ge     = w_sh >= {1'b0, r_mb};
  assign w_diff   = w_sh[M-1:0] - r_mb;
  assign w_rem_nx = w_ge ? w_diff : w_sh[M-1:0];
  assign w_quo_nx = {r_quo[M-2:0], w_ge};

  assign w_dz    = (r_mb == '0);
  assign w_divop = (r_op == OP_DIV) || (r_op == OP_MOD);
  assign w_iter  = (r_op == OP_MUL) || (w_divop && !w_dz);
  assign w_last  = !w_iter || (r_cnt == CW'(M - 1));

  assign w_va = f_sgn(r_sa, W'(r_ma));
  assign w_vb = f_sgn(r_sb, W'(r_mb));

  always_comb begin
    w_res = '0;
    case (r_op)
      OP_ADD: w_res = w_va + w_vb;
      OP_SUB: w_res = w_va - w_vb;
      OP_MUL: w_res = f_sgn(r_sa ^ r_sb, W'(w_acc_nx));
      OP_DIV: w_res = w_dz ? '0 : f_sgn(r_sa ^ r_sb, W'(w_quo_nx));
      OP_MOD: w_res = w_dz ? w_va : f_sgn(r_sa, W'(w_rem_nx));
      default: w_res = '0;
    endcase
  end

  // A truncated magnitude of zero never carries a minus sign
  assign w_neg  = w_res[W-1];
  assign w_lo   = w_res[M-1:0];
  assign w_smag = w_neg ? (M'(0) - w_lo) : w_lo;
  assign w_sm   = {w_neg && (w_smag != '0), w_smag};

`ifdef ALU_FLAGS_EN
  logic [W-1:0] w_abs;
  logic [3:0]   w_flags;
  logic [3:0]   r_flags;

  assign w_abs   = w_neg ? (W'(0) - w_res) : w_res;
  assign w_flags = {w_abs > W'((1 << M) - 1),
                    w_dz && w_divop,
                    w_neg,
                    w_res == '0};
  assign flags   = r_flags;
`else
  assign flags = 4'b0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_res_c     <= '0;
      r_res_sm    <= '0;
      r_op        <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
`ifdef ALU_FLAGS_EN
      r_flags     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_sa       <= a[N-1];
            r_sb       <= b[N-1];
            r_ma       <= a[M-1:0];
            r_mb       <= b[M-1:0];
            r_acc      <= '0;
            r_mcand    <= (2*M)'(a[M-1:0]);
            r_mplier   <= b[M-1:0];
            r_rem      <= '0;
            r_quo      <= a[M-1:0];
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nx;
          r_quo    <= w_quo_nx;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_res_c     <= w_res;
            r_res_sm    <= w_sm;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef ALU_FLAGS_EN
            r_flags     <= w_flags;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_signmag_seq.sv
// tb_alu_signmag_seq: random and directed ops against an integer model.
// Honours ALU_FLAGS_EN the same way as the design.
module tb_alu_signmag_seq;
  localparam int N = 6;
  localparam int M = N - 1;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] res_c;
  logic [N-1:0] res_sm;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  logic         exp_on = 1'b0;
  logic [W-1:0] exp_c = '0;
  logic [N-1:0] exp_sm = '0;
  logic [3:0]   exp_fl = '0;

  alu_signmag_seq #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res_c(res_c),
    .res_sm(res_sm),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer arithmetic on the decoded operands
  function automatic void model(
    input  logic [2:0]   o,
    input  logic [N-1:0] ia,
    input  logic [N-1:0] ib,
    output logic [W-1:0] c,
    output logic [N-1:0] sm,
    output logic [3:0]   fl,
    output int           lat
  );
    int va, vb, r, mag, tm;
    logic dz, sgn;
    va = ia[N-1] ? -int'(ia[M-1:0]) : int'(ia[M-1:0]);
    vb = ib[N-1] ? -int'(ib[M-1:0]) : int'(ib[M-1:0]);
    dz = 1'b0;
    lat = 1;
    case (o)
      3'd0: r = va + vb;
      3'd1: r = va - vb;
      3'd2: begin r = va * vb; lat = M; end
      3'd3: begin
        if (vb == 0) begin r = 0; dz = 1'b1; end
        else begin r = va / vb; lat = M; end
      end
      3'd4: begin
        if (vb == 0) begin r = va; dz = 1'b1; end
        else begin r = va % vb; lat = M; end
      end
      default: r = 0;
    endcase
    c = W'(r);
    mag = (r < 0) ? -r : r;
    tm = mag % (1 << M);
    sgn = (r < 0) && (tm != 0);
    sm = {sgn, M'(tm)};
`ifdef ALU_FLAGS_EN
    fl = {mag > ((1 << M) - 1), dz, r < 0, r == 0};
`else
    fl = 4'b0000;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_on) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("res_c", int'(res_c), int'(exp_c));
        chk("res_sm", int'(res_sm), int'(exp_sm));
        chk("flags", int'(flags), int'(exp_fl));
      end
    end
  end

  task automatic recover();
    @(negedge clk);
    exp_on = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(
    input logic [2:0]   o,
    input logic [N-1:0] ia,
    input logic [N-1:0] ib,
    input int           hold
  );
    logic [W-1:0] c;
    logic [N-1:0] sm;
    logic [3:0]   fl;
    int lat, cyc, w;
    model(o, ia, ib, c, sm, fl, lat);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("idle_timeout", 0, 1);
      recover();
      return;
    end
    exp_c = c;
    exp_sm = sm;
    exp_fl = fl;
    exp_on = 1'b1;
    op = o;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = N'($urandom);
    b = N'($urandom);
    chk("in_ready_after_accept", int'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    if (!out_valid) begin
      recover();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_out_valid", int'(out_valid), 0);
    chk("consume_in_ready", int'(in_ready), 1);
    chk("consume_res_held", int'(res_c), int'(c));
    exp_on = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] c;
    logic [N-1:0] sm;
    logic [3:0]   fl;
    int lat;

    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_res_c", int'(res_c), 0);
    chk("rst_res_sm", int'(res_sm), 0);
    chk("rst_flags", int'(flags), 0);
    @(negedge clk);
    rst = 1'b0;

    model(3'd0, 6'b000101, 6'b100011, c, sm, fl, lat);
    chk("pin_add", int'({c, sm}), int'({12'h002, 6'b000010}));
    chk("pin_add_lat", lat, 1);
    model(3'd2, 6'b100111, 6'b000110, c, sm, fl, lat);
    chk("pin_mul", int'({c, sm}), int'({12'hFD6, 6'b101010}));
    chk("pin_mul_lat", lat, 5);
    model(3'd3, 6'b111101, 6'b000100, c, sm, fl, lat);
    chk("pin_div", int'({c, sm}), int'({12'hFF9, 6'b100111}));
    model(3'd4, 6'b111101, 6'b000100, c, sm, fl, lat);
    chk("pin_mod", int'({c, sm}), int'({12'hFFF, 6'b100001}));
    model(3'd3, 6'b001001, 6'b100000, c, sm, fl, lat);
    chk("pin_dz", int'({c, sm}), 0);
    chk("pin_dz_lat", lat, 1);
`ifdef ALU_FLAGS_EN
    model(3'd2, 6'b100111, 6'b000110, c, sm, fl, lat);
    chk("pin_mul_flags", int'(fl), int'(4'b1010));
    model(3'd3, 6'b001001, 6'b100000, c, sm, fl, lat);
    chk("pin_dz_flags", int'(fl), int'(4'b0101));
`endif

    run_op(3'd0, 6'b000101, 6'b100011, 0);
    run_op(3'd2, 6'b100111, 6'b000110, 0);
    run_op(3'd3, 6'b111101, 6'b000100, 0);
    run_op(3'd4, 6'b111101, 6'b000100, 0);
    run_op(3'd3, 6'b001001, 6'b100000, 0);
    run_op(3'd4, 6'b101001, 6'b000000, 3);
    run_op(3'd2, 6'b100100, 6'b001000, 1);
    run_op(3'd1, 6'b011111, 6'b111111, 0);
    run_op(3'd6, 6'b011111, 6'b000001, 0);

    // Abort a multiply two cycles into execution
    @(negedge clk);
    op = 3'd2;
    a = 6'b011111;
    b = 6'b011111;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_result", int'(out_valid), 0);
    end
    run_op(3'd2, 6'b100011, 6'b000101, 0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0]   ro;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ro = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                     : 3'($urandom_range(5, 7));
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 7) == 0) rb = {1'($urandom), {M{1'b0}}};
      run_op(ro, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
